ddc_pri_sched: RTL and testbench
================================

Name: ddc_pri_sched

Overview:
- PRI-synchronised scheduler for the DDC datapath.
- Generates the SEG_W-bit decimation phase (segment), realigned to 0 on every PRI rising edge.
- Sequences a per-PRI receive window (delay, then capture of N decimated samples) with SOF/EOF framing for the downstream packer/SRIO path.
- Flags PRI overruns and counts PRIs.

Parameters:
- SEG_W, 2, segment width; decimation factor = 2^SEG_W.
- CNT_W, 16, width of delay/length/sample counters.
- PRI_CNT_W, 16, width of PRI counter.

Ports:
- clk  in  1  DDC clock, 100 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- pri  in  1  PRI marker, level, synchronous to clk.
- cfg_en  in  1  window sequencing enable.
- cfg_delay  in  CNT_W  window start delay, in decimated strobes.
- cfg_len  in  CNT_W  window length, in decimated strobes.
- err_clr  in  1  clears err_overrun.
- segment  out  SEG_W  decimation phase to DDC.
- win_valid  out  1  capture strobe to DDC output stage.
- win_sof  out  1  first win_valid of window.
- win_eof  out  1  last win_valid of window.
- win_abort  out  1  1-cycle pulse: window killed by PRI.
- samp_idx  out  CNT_W  index of current win_valid sample, 0-based.
- pri_cnt  out  PRI_CNT_W  PRI rising edges seen since reset, wraps.
- busy  out  1  state != IDLE.
- err_overrun  out  1  sticky: PRI arrived while busy.
- pri_ts  out  32  PRI timestamp (see Optional Feature).

Behaviour:
- Reset values:
  - segment=0, state=IDLE; all pulse outputs 0.
  - samp_idx=0, pri_cnt=0, err_overrun=0, pri_ts=0, pri_q=0.
- Edge detection: pri_q <= pri each cycle; pri_rise = pri & ~pri_q (combinational). Level held high gives exactly one rise.
- Segment:
  - Cycle after pri_rise: segment=0.
  - Otherwise segment increments every cycle, wrapping 2^SEG_W-1 -> 0.
  - Realignment is independent of cfg_en and state.
- Strobe: strb = (segment == all-ones). The first strobe after PRI occurs 2^SEG_W cycles after the pri_rise cycle.
- pri_cnt increments on every pri_rise.
- On pri_rise with cfg_en=1: cfg_delay and cfg_len are latched. Config changes mid-window have no effect.
- FSM states: IDLE, DELAY, CAPTURE.
  - IDLE: on pri_rise & cfg_en:
    - cfg_len==0 -> stay IDLE; no window.
    - else cfg_delay==0 -> CAPTURE.
    - else -> DELAY (dly_cnt=cfg_delay).
  - DELAY: dly_cnt decrements on each strb; on the strb where dly_cnt==1 -> CAPTURE.
  - CAPTURE:
    - Each strb: win_valid=1 (same cycle as strb, registered outputs aligned with segment), samp_idx=count, then count++.
    - win_sof with count 0; win_eof with count cfg_len-1.
    - After the eof cycle -> IDLE.
    - cfg_len==1 gives sof and eof in the same cycle.
  - Outputs are registered: win_valid/sof/eof/samp_idx change on the clock edge that makes segment all-ones.
- PRI while busy (DELAY or CAPTURE):
  - win_abort pulses for 1 cycle; no win_eof for the aborted window.
  - err_overrun set.
  - Window restarts per the IDLE rules using the newly latched config.
- PRI while busy with cfg_en=0: abort, overrun set, -> IDLE.
- cfg_en deasserted mid-window: current window completes normally.
- err_clr and an overrun set in the same cycle: set wins.
- Counters saturate nowhere; CNT_W arithmetic is unsigned, and samp_idx never exceeds cfg_len-1.
- rst_n low mid-window: all state returns to reset values next edge; no eof/abort emitted.

Optional Feature:
- Macro: DDC_SCHED_TS_EN.
- Defined: a free-running 32-bit cycle counter (reset 0, wraps) is latched into pri_ts on every pri_rise.
- Undefined: no counter is instantiated; pri_ts is tied to 0. Port list is unchanged.

Decomposition:
- Package ddc_sched_pkg holds:
  - FSM state encoding (IDLE=2'd0, DELAY=2'd1, CAPTURE=2'd2).
  - Default SEG_W/CNT_W localparams.
- One sub-module, ddc_seg_phase: pri edge detect, segment counter, strb generation.
- FSM and window counters stay in the top level.

Test Plan:
- Reset with pri=0: all outputs 0; after release, segment counts 0,1,2,3,0…
- cfg_delay=2, cfg_len=3, pri pulse at cycle T:
  - segment=0 at T+1.
  - win_valid at the 3rd, 4th and 5th strobes with samp_idx 0,1,2.
  - sof on the first, eof on the last; busy drops the cycle after eof.
- cfg_len=0, pri pulse: no win_valid, pri_cnt=1, busy stays 0. cfg_len=1, cfg_delay=0: single cycle with sof=eof=1, samp_idx=0.
- Overrun and clear:
  - cfg_len=100; second pri after 20 samples: win_abort pulse, err_overrun=1, new sof with samp_idx=0, no eof from the first window.
  - err_clr asserted simultaneously with a third overrun: err_overrun stays 1.
- pri held high 50 cycles: one rise only, pri_cnt +1. rst_n asserted mid-CAPTURE: next edge state IDLE, samp_idx=0, no eof.
- With DDC_SCHED_TS_EN: pri rises at cycles 10 and 1010 after reset -> pri_ts = 10 then 1010 (exact offset per latch edge). Without the macro: pri_ts=0 throughout.

Source files
------------

// File: rtl/ddc_sched_pkg.sv
// ddc_sched_pkg: shared FSM encoding and default widths for the DDC PRI scheduler
package ddc_sched_pkg;
  localparam int SEG_W_DEF = 2;
  localparam int CNT_W_DEF = 16;
  localparam int PRI_CNT_W_DEF = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/ddc_seg_phase.sv
// ddc_seg_phase: PRI edge detect, decimation phase counter and next-cycle strobe
module ddc_seg_phase
  import ddc_sched_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pri,
  output logic [SEG_W-1:0] segment,
  output logic             pri_rise,
  output logic             strb_nxt
);
  logic pri_q;
  assign pri_rise = pri & ~pri_q;
  // strobe lands in the next cycle, so registered window outputs line up with segment all-ones
  assign strb_nxt = ~pri_rise & (&(segment + SEG_W'(1)));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_q   <= 1'b0;
      segment <= '0;
    end else begin
      pri_q   <= pri;
      segment <= pri_rise ? '0 : segment + SEG_W'(1);
    end
  end
endmodule

// File: rtl/ddc_pri_sched.sv
// ddc_pri_sched: PRI-synchronised receive window scheduler with SOF/EOF framing
// DDC_SCHED_TS_EN adds a 32-bit cycle timestamp latched on each PRI rise.
module ddc_pri_sched
  import ddc_sched_pkg::*;
#(
  parameter int SEG_W     = SEG_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PRI_CNT_W = PRI_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pri,
  input  logic                 cfg_en,
  input  logic [CNT_W-1:0]     cfg_delay,
  input  logic [CNT_W-1:0]     cfg_len,
  input  logic                 err_clr,
  output logic [SEG_W-1:0]     segment,
  output logic                 win_valid,
  output logic                 win_sof,
  output logic                 win_eof,
  output logic                 win_abort,
  output logic [CNT_W-1:0]     samp_idx,
  output logic [PRI_CNT_W-1:0] pri_cnt,
  output logic                 busy,
  output logic                 err_overrun,
  output logic [31:0]          pri_ts
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic pri_rise, strb_nxt;
  state_t state, start_state;
  logic [CNT_W-1:0] len_q, dly_cnt, cnt;

  ddc_seg_phase #(.SEG_W(SEG_W)) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pri     (pri),
    .segment (segment),
    .pri_rise(pri_rise),
    .strb_nxt(strb_nxt)
  );

  always_comb
    start_state = (!cfg_en || cfg_len == '0) ? IDLE : (cfg_delay == '0 ? CAPTURE : DELAY);

  assign busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      dly_cnt     <= '0;
      cnt         <= '0;
      win_valid   <= 1'b0;
      win_sof     <= 1'b0;
      win_eof     <= 1'b0;
      win_abort   <= 1'b0;
      samp_idx    <= '0;
      pri_cnt     <= '0;
      err_overrun <= 1'b0;
    end else begin
      win_valid   <= 1'b0;
      win_sof     <= 1'b0;
      win_eof     <= 1'b0;
      win_abort   <= 1'b0;
      err_overrun <= (pri_rise & busy) | (err_overrun & ~err_clr);
      if (pri_rise) begin
        pri_cnt   <= pri_cnt + PRI_CNT_W'(1);
        win_abort <= busy;
        state     <= start_state;
        cnt       <= '0;
        if (cfg_en) begin
          len_q   <= cfg_len;
          dly_cnt <= cfg_delay;
        end
      end else if (state == CAPTURE && win_eof) begin
        state <= IDLE;
      end else if (strb_nxt && state == DELAY) begin
        if (dly_cnt == ONE) state <= CAPTURE;
        dly_cnt <= dly_cnt - ONE;
      end else if (strb_nxt && state == CAPTURE) begin
        win_valid <= 1'b1;
        win_sof   <= cnt == '0;
        win_eof   <= cnt + ONE == len_q;
        samp_idx  <= cnt;
        cnt       <= cnt + ONE;
      end
    end
  end

`ifdef DDC_SCHED_TS_EN
  logic [31:0] ts_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      pri_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (pri_rise) pri_ts <= ts_cnt;
    end
  end
`else
  assign pri_ts = '0;
`endif
endmodule

// File: tb/tb_ddc_pri_sched.sv
// tb_ddc_pri_sched: directed self-checking bench for ddc_pri_sched
module tb_ddc_pri_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pri = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [15:0] cfg_len = '0;
  logic        err_clr = 1'b0;
  logic [1:0]  segment;
  logic        win_valid, win_sof, win_eof, win_abort, busy, err_overrun;
  logic [15:0] samp_idx, pri_cnt;
  logic [31:0] pri_ts;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_pri_cnt = '0;

  ddc_pri_sched dut (
    .clk(clk), .rst_n(rst_n), .pri(pri), .cfg_en(cfg_en), .cfg_delay(cfg_delay),
    .cfg_len(cfg_len), .err_clr(err_clr), .segment(segment), .win_valid(win_valid),
    .win_sof(win_sof), .win_eof(win_eof), .win_abort(win_abort), .samp_idx(samp_idx),
    .pri_cnt(pri_cnt), .busy(busy), .err_overrun(err_overrun), .pri_ts(pri_ts)
  );

  always #5 clk = ~clk;

  task automatic pulse_pri();
    @(negedge clk) pri = 1'b1;
    @(negedge clk) pri = 1'b0;
    exp_pri_cnt++;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    repeat (3) @(negedge clk);
    got = {win_valid, win_sof, win_eof, win_abort, busy, err_overrun, |segment};
    checks++;
    if (got !== 7'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000000", got); end
    checks++;
    if (samp_idx !== 16'd0 || pri_cnt !== 16'd0 || pri_ts !== 32'd0) begin
      failures++; $display("FAIL reset_counts idx=%0d cnt=%0d ts=%0d exp=0", samp_idx, pri_cnt, pri_ts);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (segment !== 2'(k)) begin failures++; $display("FAIL reset_segment k=%0d got=%0d exp=%0d", k, segment, 2'(k)); end
      @(negedge clk);
    end
  endtask

  task automatic test_window();
    int nv = 0;
    logic [4:0] ef, gf;
    cfg_en = 1'b1; cfg_delay = 16'd2; cfg_len = 16'd3;
    pulse_pri();
    cfg_delay = 16'd5; cfg_len = 16'd7;
    for (int t = 0; t < 24; t++) begin
      ef = {t == 11 || t == 15 || t == 19, t == 11, t == 19, t < 20, 1'b0};
      gf = {win_valid, win_sof, win_eof, busy, win_abort};
      checks++;
      if (gf !== ef) begin failures++; $display("FAIL window_flags t=%0d got=%b exp=%b", t, gf, ef); end
      checks++;
      if (segment !== 2'(t)) begin failures++; $display("FAIL window_segment t=%0d got=%0d exp=%0d", t, segment, 2'(t)); end
      if (win_valid) begin
        checks++;
        if (samp_idx !== 16'(nv)) begin failures++; $display("FAIL window_idx t=%0d got=%0d exp=%0d", t, samp_idx, nv); end
        nv++;
      end
      @(negedge clk);
    end
    checks++;
    if (pri_cnt !== exp_pri_cnt) begin failures++; $display("FAIL window_pri_cnt got=%0d exp=%0d", pri_cnt, exp_pri_cnt); end
  endtask

  task automatic test_len0();
    int nv = 0;
    int nb = 0;
    cfg_en = 1'b1; cfg_delay = 16'd0; cfg_len = 16'd0;
    pulse_pri();
    for (int t = 0; t < 12; t++) begin
      nv += int'(win_valid);
      nb += int'(busy);
      @(negedge clk);
    end
    checks++;
    if (nv != 0 || nb != 0) begin failures++; $display("FAIL len0_activity valid=%0d busy=%0d exp=0", nv, nb); end
    checks++;
    if (pri_cnt !== exp_pri_cnt) begin failures++; $display("FAIL len0_pri_cnt got=%0d exp=%0d", pri_cnt, exp_pri_cnt); end
  endtask

  task automatic test_len1();
    logic [4:0] ef, gf;
    cfg_en = 1'b1; cfg_delay = 16'd0; cfg_len = 16'd1;
    pulse_pri();
    for (int t = 0; t < 12; t++) begin
      ef = {t == 3, t == 3, t == 3, t < 4, 1'b0};
      gf = {win_valid, win_sof, win_eof, busy, win_abort};
      checks++;
      if (gf !== ef) begin failures++; $display("FAIL len1_flags t=%0d got=%b exp=%b", t, gf, ef); end
      if (t == 3) begin
        checks++;
        if (samp_idx !== 16'd0) begin failures++; $display("FAIL len1_idx got=%0d exp=0", samp_idx); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    int nv = 0;
    int neof = 0;
    cfg_en = 1'b1; cfg_delay = 16'd0; cfg_len = 16'd100;
    pulse_pri();
    for (int t = 0; t < 200 && nv < 20; t++) begin
      nv += int'(win_valid);
      neof += int'(win_eof);
      if (nv < 20) @(negedge clk);
    end
    checks++;
    if (nv != 20) begin failures++; $display("FAIL overrun_samples got=%0d exp=20", nv); end
    pulse_pri();
    checks++;
    if ({win_abort, err_overrun, busy} !== 3'b111) begin
      failures++; $display("FAIL overrun_abort abort/err/busy got=%b exp=111", {win_abort, err_overrun, busy});
    end
    for (int t = 0; t < 8; t++) begin
      neof += int'(win_eof);
      if (t == 1) begin
        checks++;
        if (win_abort !== 1'b0) begin failures++; $display("FAIL overrun_abort_len got=%b exp=0", win_abort); end
      end
      if (t == 3) begin
        checks++;
        if ({win_valid, win_sof, samp_idx} !== {2'b11, 16'd0}) begin
          failures++; $display("FAIL overrun_restart valid=%b sof=%b idx=%0d exp=1 1 0", win_valid, win_sof, samp_idx);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (neof != 0) begin failures++; $display("FAIL overrun_no_eof got=%0d exp=0", neof); end
    @(negedge clk) begin pri = 1'b1; err_clr = 1'b1; end
    @(negedge clk) begin pri = 1'b0; err_clr = 1'b0; end
    exp_pri_cnt++;
    checks++;
    if ({win_abort, err_overrun} !== 2'b11) begin failures++; $display("FAIL overrun_set_wins got=%b exp=11", {win_abort, err_overrun}); end
    cfg_en = 1'b0;
    repeat (5) @(negedge clk);
    pulse_pri();
    checks++;
    if ({win_abort, busy, err_overrun} !== 3'b101) begin
      failures++; $display("FAIL overrun_cfg_off abort/busy/err got=%b exp=101", {win_abort, busy, err_overrun});
    end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    checks++;
    if (err_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", err_overrun); end
  endtask

  task automatic test_pri_hold();
    cfg_en = 1'b0;
    @(negedge clk) pri = 1'b1;
    repeat (50) @(negedge clk);
    pri = 1'b0;
    exp_pri_cnt++;
    repeat (3) @(negedge clk);
    checks++;
    if (pri_cnt !== exp_pri_cnt) begin failures++; $display("FAIL hold_pri_cnt got=%0d exp=%0d", pri_cnt, exp_pri_cnt); end
  endtask

  task automatic test_ts();
    logic [31:0] ts_a;
    cfg_en = 1'b0;
    pulse_pri();
    ts_a = pri_ts;
    repeat (999) @(negedge clk);
    pri = 1'b1;
    @(negedge clk) pri = 1'b0;
    exp_pri_cnt++;
`ifdef DDC_SCHED_TS_EN
    checks++;
    if (pri_ts - ts_a !== 32'd1000) begin failures++; $display("FAIL ts_delta got=%0d exp=1000", pri_ts - ts_a); end
`else
    checks++;
    if (ts_a !== 32'd0 || pri_ts !== 32'd0) begin failures++; $display("FAIL ts_zero got=%0d,%0d exp=0", ts_a, pri_ts); end
`endif
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    cfg_en = 1'b1; cfg_delay = 16'd0; cfg_len = 16'd10;
    pulse_pri();
    repeat (11) @(negedge clk);
    checks++;
    if ({win_valid, samp_idx} !== {1'b1, 16'd2}) begin failures++; $display("FAIL mid_capture valid=%b idx=%0d exp=1 2", win_valid, samp_idx); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, win_valid, win_eof, win_abort, samp_idx, pri_cnt, segment} !== '0) begin
      failures++; $display("FAIL mid_reset busy=%b valid=%b eof=%b abort=%b idx=%0d cnt=%0d seg=%0d exp=0",
                           busy, win_valid, win_eof, win_abort, samp_idx, pri_cnt, segment);
    end
    for (int t = 0; t < 6; t++) begin
      bad += int'(win_eof | win_abort);
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mid_reset_pulses got=%0d exp=0", bad); end
    rst_n = 1'b1;
    exp_pri_cnt = '0;
  endtask

  initial begin
    test_reset();
    test_window();
    test_len0();
    test_len1();
    test_overrun();
    test_pri_hold();
    test_ts();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
